// File: rtl/atmospheric_light_estimator_pkg.sv
// Shared definitions for the atmospheric light estimator.
// Holds the default pixel width and the accumulator FSM state encoding.
package atmospheric_light_estimator_pkg;

    localparam int DW_DEFAULT = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/atmospheric_light_estimator_if.sv
// Pixel stream in / atmospheric light result out bundle.
// master: pixel source and result consumer; slave: the estimator.
//   in_valid/in_sof/in_eof, in_r/g/b : pixel stream (no backpressure)
//   atm_r/g/b, atm_dark, atm_valid   : result, held until atm_ready
//   frame_err, atm_overrun           : single-cycle status pulses
interface atmospheric_light_estimator_if
    import atmospheric_light_estimator_pkg::*;
#(
    parameter int DATA_WIDTH = DW_DEFAULT
);
    logic                  in_valid;
    logic                  in_sof;
    logic                  in_eof;
    logic [DATA_WIDTH-1:0] in_r;
    logic [DATA_WIDTH-1:0] in_g;
    logic [DATA_WIDTH-1:0] in_b;
    logic [DATA_WIDTH-1:0] atm_r;
    logic [DATA_WIDTH-1:0] atm_g;
    logic [DATA_WIDTH-1:0] atm_b;
    logic [DATA_WIDTH-1:0] atm_dark;
    logic                  atm_valid;
    logic                  atm_ready;
    logic                  frame_err;
    logic                  atm_overrun;

    modport master (
        output in_valid, in_sof, in_eof,
        output in_r, in_g, in_b,
        output atm_ready,
        input  atm_r, atm_g, atm_b, atm_dark,
        input  atm_valid, frame_err, atm_overrun
    );

    modport slave (
        input  in_valid, in_sof, in_eof,
        input  in_r, in_g, in_b,
        input  atm_ready,
        output atm_r, atm_g, atm_b, atm_dark,
        output atm_valid, frame_err, atm_overrun
    );

endinterface

// File: rtl/atmospheric_light_estimator_min3.sv
// Combinational unsigned minimum of three channels (dark channel value).
// Ports: i_a, i_b, i_c channel inputs; o_min smallest of the three.
module dark_value_min3
    import atmospheric_light_estimator_pkg::*;
#(
    parameter int DATA_WIDTH = DW_DEFAULT
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic [DATA_WIDTH-1:0] i_c,
    output logic [DATA_WIDTH-1:0] o_min
);

    logic [DATA_WIDTH-1:0] w_ab;

    assign w_ab  = (i_a < i_b) ? i_a : i_b;
    assign o_min = (w_ab < i_c) ? w_ab : i_c;

endmodule

// File: rtl/atmospheric_light_estimator.sv
// Tracks the brightest dark-channel pixel of each frame and presents it
// as the atmospheric light estimate. Ports: clk, rst (sync, active high),
// bus (slave side of atmospheric_light_estimator_if).
module atmospheric_light_estimator
    import atmospheric_light_estimator_pkg::*;
#(
    parameter int DATA_WIDTH = DW_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    atmospheric_light_estimator_if.slave  bus
);

    localparam int DW = DATA_WIDTH;

    logic [DW-1:0] w_dark;

    // Stage 1 registers
    logic          r_s1_valid;
    logic          r_s1_sof;
    logic          r_s1_eof;
    logic [DW-1:0] r_s1_r;
    logic [DW-1:0] r_s1_g;
    logic [DW-1:0] r_s1_b;
    logic [DW-1:0] r_s1_dark;

    // Stage 2 state
    state_t        r_state;
    logic [DW-1:0] r_max_r;
    logic [DW-1:0] r_max_g;
    logic [DW-1:0] r_max_b;
    logic [DW-1:0] r_max_dark;
    logic [DW-1:0] r_atm_r;
    logic [DW-1:0] r_atm_g;
    logic [DW-1:0] r_atm_b;
    logic [DW-1:0] r_atm_dark;
    logic          r_atm_valid;
    logic          r_frame_err;
    logic          r_overrun;

    logic          w_in_accum;
    logic          w_load_max;
    logic          w_done;
    logic          w_ferr;
    logic [DW-1:0] w_win_r;
    logic [DW-1:0] w_win_g;
    logic [DW-1:0] w_win_b;
    logic [DW-1:0] w_win_dark;

    dark_value_min3 #(
        .DATA_WIDTH (DW)
    ) u_min3 (
        .i_a   (bus.in_r),
        .i_b   (bus.in_g),
        .i_c   (bus.in_b),
        .o_min (w_dark)
    );

    always_comb begin
        w_in_accum = (r_state == ST_ACCUM);
        // sof always reloads; otherwise strictly greater keeps the
        // first maximum in raster order
        w_load_max = r_s1_valid &&
                     (r_s1_sof ||
                      (w_in_accum && (r_s1_dark > r_max_dark)));
        // eof in IDLE without sof belongs to no frame and is dropped
        w_done     = r_s1_valid && r_s1_eof &&
                     (r_s1_sof || w_in_accum);
        w_ferr     = r_s1_valid && r_s1_sof && w_in_accum;
        w_win_r    = w_load_max ? r_s1_r    : r_max_r;
        w_win_g    = w_load_max ? r_s1_g    : r_max_g;
        w_win_b    = w_load_max ? r_s1_b    : r_max_b;
        w_win_dark = w_load_max ? r_s1_dark : r_max_dark;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_sof    <= 1'b0;
            r_s1_eof    <= 1'b0;
            r_s1_r      <= '0;
            r_s1_g      <= '0;
            r_s1_b      <= '0;
            r_s1_dark   <= '0;
            r_state     <= ST_IDLE;
            r_max_r     <= '0;
            r_max_g     <= '0;
            r_max_b     <= '0;
            r_max_dark  <= '0;
            r_atm_r     <= '0;
            r_atm_g     <= '0;
            r_atm_b     <= '0;
            r_atm_dark  <= '0;
            r_atm_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_s1_valid  <= bus.in_valid;
            r_s1_sof    <= bus.in_sof;
            r_s1_eof    <= bus.in_eof;
            r_s1_r      <= bus.in_r;
            r_s1_g      <= bus.in_g;
            r_s1_b      <= bus.in_b;
            r_s1_dark   <= w_dark;

            r_frame_err <= w_ferr;
            // a new result replacing one the consumer never took
            r_overrun   <= w_done && r_atm_valid && !bus.atm_ready;

            if (w_load_max) begin
                r_max_r    <= r_s1_r;
                r_max_g    <= r_s1_g;
                r_max_b    <= r_s1_b;
                r_max_dark <= r_s1_dark;
            end

            if (r_s1_valid) begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (r_s1_sof && !r_s1_eof) begin
                            r_state <= ST_ACCUM;
                        end
                    end
                    ST_ACCUM: begin
                        if (r_s1_eof) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end

            // a new result has priority over a same-edge acceptance
            if (w_done) begin
                r_atm_r     <= w_win_r;
                r_atm_g     <= w_win_g;
                r_atm_b     <= w_win_b;
                r_atm_dark  <= w_win_dark;
                r_atm_valid <= 1'b1;
            end else if (bus.atm_ready) begin
                r_atm_valid <= 1'b0;
            end
        end
    end

    assign bus.atm_r       = r_atm_r;
    assign bus.atm_g       = r_atm_g;
    assign bus.atm_b       = r_atm_b;
    assign bus.atm_dark    = r_atm_dark;
    assign bus.atm_valid   = r_atm_valid;
    assign bus.frame_err   = r_frame_err;
    assign bus.atm_overrun = r_overrun;

endmodule

// File: doc/atmospheric_light_estimator.md
ATMOSPHERIC_LIGHT_ESTIMATOR -- requirements
Module: atmospheric_light_estimator

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the per-channel pixel width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: input pixel qualifier.
REQ-005 The block SHALL have port in_sof, input, 1 bit: first pixel of frame, meaningful only with in_valid.
REQ-006 The block SHALL have port in_eof, input, 1 bit: last pixel of frame, meaningful only with in_valid.
REQ-007 The block SHALL have ports in_r, in_g, in_b, input, DATA_WIDTH each: pixel channels.
REQ-008 The block SHALL have ports atm_r, atm_g, atm_b, output, DATA_WIDTH each: estimated atmospheric light.
REQ-009 The block SHALL have port atm_dark, output, DATA_WIDTH: dark value of the selected pixel.
REQ-010 The block SHALL have port atm_valid, output, 1 bit: result valid.
REQ-011 The block SHALL have port atm_ready, input, 1 bit: consumer accepts the result.
REQ-012 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on an in_sof seen while in ACCUM.
REQ-013 The block SHALL have port atm_overrun, output, 1 bit: one-cycle pulse when an unaccepted result is overwritten.

Function
REQ-014 The input SHALL be accepted unconditionally on every cycle with in_valid=1; there is no input backpressure.
REQ-015 Stage 1 SHALL register the pixel, in_sof, in_eof, in_valid, and dark = min(in_r,in_g,in_b), unsigned, DATA_WIDTH wide.
REQ-016 Stage 2 SHALL be an FSM with states IDLE and ACCUM, acting only on valid stage-1 entries; bubbles leave all state unchanged.
REQ-017 In IDLE, entries without sof SHALL be ignored; an sof entry SHALL load the running max (dark, r, g, b) unconditionally and move the FSM to ACCUM.
REQ-018 In ACCUM, the running max SHALL be replaced only when the entry's dark is strictly greater than it, so the first maximum pixel in raster order is kept.
REQ-019 In ACCUM, an sof entry SHALL pulse frame_err, discard the partial result, and reload the running max from that entry; the FSM stays in ACCUM.
REQ-020 An eof entry SHALL be compared per REQ-017/018 first; the final winner SHALL be loaded into the atm_* registers on the same edge, set atm_valid, and return the FSM to IDLE.
REQ-021 An entry with both sof and eof (single-pixel frame) SHALL produce that pixel as the result.
REQ-022 Latency SHALL be exactly 2 clock edges from sampling the eof pixel to atm_valid=1.
REQ-023 While atm_valid=1, the atm_* outputs SHALL remain stable until a clock edge with atm_ready=1, which clears atm_valid.
REQ-024 If a new result loads on the same edge as an acceptance, the new result SHALL win and atm_valid SHALL stay 1, with no atm_overrun.
REQ-025 If a new result loads while atm_valid=1 and atm_ready=0, the result SHALL be overwritten and atm_overrun SHALL pulse for one cycle.

Reset
REQ-026 On rst, the FSM SHALL go to IDLE, stage-1 valid SHALL clear, the running max SHALL clear, and atm_r/g/b, atm_dark, atm_valid, frame_err and atm_overrun SHALL all be 0.
REQ-027 A reset mid-frame SHALL discard the partial frame; a later eof without a preceding sof SHALL produce no result.

Structure
REQ-028 A shared package SHALL hold the DATA_WIDTH default and the FSM state encoding (IDLE=0, ACCUM=1).
REQ-029 The 3-input minimum SHALL be a combinational sub-module named dark_value_min3; the max tracking and handshake SHALL stay in the top module.

Verification
REQ-030 Scenario: frame (10,20,30)sof, (200,180,190), (90,250,95), (5,5,5)eof -> atm=(200,180,190), atm_dark=180, atm_valid 2 edges after eof, held while atm_ready=0.
REQ-031 Scenario: tie, frame (100,120,130)sof, (110,100,140)eof, both dark 100 -> result is (100,120,130).
REQ-032 Scenario: single entry (7,3,9) with sof and eof -> atm=(7,3,9), atm_dark=3.
REQ-033 Scenario: sof (250,250,250), then sof (1,2,3), then eof (4,5,6) -> one frame_err pulse; result (4,5,6), atm_dark=4.
REQ-034 Scenario: with atm_ready=0, two back-to-back frames -> atm_overrun pulses once; outputs hold the second frame's result.
REQ-035 Scenario: rst asserted after sof (255,255,255), followed by eof (9,9,9) -> atm_valid stays 0 and all outputs remain 0.
